// File: rtl/serial_comp_ctrl.sv
// serial_comp_ctrl: compares two WIDTH-bit operands two bits per cycle,
// MSB slice first, through a single 2-bit comparator.
//
// Ports:
//   clk   - clock, all state changes on rising edge
//   rst   - asynchronous active-high reset
//   start - compare request, accepted only in IDLE (a/b latched with it)
//   a, b  - operands
//   busy  - comparison in progress
//   done  - one-cycle pulse when gt/lt/eq are updated
//   gt/lt/eq - latched result, held until the next completed comparison
//
// Build option: define SERIAL_COMP_EARLY_EXIT_EN to finish at the first
// deciding slice; otherwise every comparison takes NSLICE cycles.

// 2-bit magnitude comparator
module comp2 (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic       gt_c,
   output logic       lt_c,
   output logic       eq_c
);
   assign gt_c = (a > b);
   assign lt_c = (a < b);
   assign eq_c = (a == b);
endmodule

module serial_comp_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             lt,
   output logic             eq
);
   localparam int unsigned NSLICE = WIDTH / 2;
   localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

`ifdef SERIAL_COMP_EARLY_EXIT_EN
   localparam bit EARLY_EXIT = 1'b1;
`else
   localparam bit EARLY_EXIT = 1'b0;
`endif

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               decided_q, decided_d;
   logic               dgt_q, dgt_d, dlt_q, dlt_d;
   logic               busy_d, done_d, gt_d, lt_d, eq_d;

   logic [1:0]         slice_a, slice_b;
   logic               s_gt_c, s_lt_c, s_eq_c;
   logic               fin_gt, fin_lt, term;

   assign slice_a = a_q[{idx_q, 1'b0} +: 2];
   assign slice_b = b_q[{idx_q, 1'b0} +: 2];

   comp2 u_comp2 (
      .a    (slice_a),
      .b    (slice_b),
      .gt_c (s_gt_c),
      .lt_c (s_lt_c),
      .eq_c (s_eq_c)
   );

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         idx_q     <= '0;
         decided_q <= 1'b0;
         dgt_q     <= 1'b0;
         dlt_q     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         gt        <= 1'b0;
         lt        <= 1'b0;
         eq        <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         idx_q     <= idx_d;
         decided_q <= decided_d;
         dgt_q     <= dgt_d;
         dlt_q     <= dlt_d;
         busy      <= busy_d;
         done      <= done_d;
         gt        <= gt_d;
         lt        <= lt_d;
         eq        <= eq_d;
      end
   end

   // Next-state and output logic
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      idx_d     = idx_q;
      decided_d = decided_q;
      dgt_d     = dgt_q;
      dlt_d     = dlt_q;
      busy_d    = busy;
      done_d    = 1'b0;
      gt_d      = gt;
      lt_d      = lt;
      eq_d      = eq;

      // An earlier deciding slice always wins over the current one.
      fin_gt = decided_q ? dgt_q : s_gt_c;
      fin_lt = decided_q ? dlt_q : s_lt_c;
      term   = (idx_q == '0) || (EARLY_EXIT && !s_eq_c);

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d       = a;
               b_d       = b;
               idx_d     = IDX_W'(NSLICE - 1);
               decided_d = 1'b0;
               busy_d    = 1'b1;
               state_d   = RUN;
            end
         end
         RUN: begin
            if (!decided_q && !s_eq_c) begin
               decided_d = 1'b1;
               dgt_d     = s_gt_c;
               dlt_d     = s_lt_c;
            end
            if (term) begin
               gt_d    = fin_gt;
               lt_d    = fin_lt;
               eq_d    = !(fin_gt || fin_lt);
               done_d  = 1'b1;
               busy_d  = 1'b0;
               idx_d   = '0;
               state_d = IDLE;
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_serial_comp_ctrl.sv
// Self-checking bench for serial_comp_ctrl (WIDTH=8). Honours
// SERIAL_COMP_EARLY_EXIT_EN when computing expected latency.
module tb_serial_comp_ctrl;
   localparam int unsigned WIDTH  = 8;
   localparam int unsigned NSLICE = WIDTH / 2;
`ifdef SERIAL_COMP_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             busy, done, gt, lt, eq;

   int n_cmp = 0;
   int n_err = 0;

   serial_comp_ctrl #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .gt(gt), .lt(lt), .eq(eq)
   );

   always #5 clk = ~clk;

   // Reference: cycles from accept to done, from the first differing 2-bit slice
   function automatic int exp_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      int first = NSLICE;
      for (int k = NSLICE - 1; k >= 0; k--)
         if (first == NSLICE && ((x >> (2 * k)) & 8'h03) != ((y >> (2 * k)) & 8'h03))
            first = NSLICE - k;
      return EARLY ? first : NSLICE;
   endfunction

   function automatic logic [2:0] exp_res(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      return {x > y, x < y, x == y};
   endfunction

   task automatic launch(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      @(negedge clk);
      a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Wait for done (bounded); operands are scrambled every cycle meanwhile.
   task automatic wait_done(output int edges, output bit busy_ok, output bit held_ok);
      logic [2:0] prev;
      prev = {gt, lt, eq};
      edges = -1; busy_ok = 1'b1; held_ok = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         a = WIDTH'($urandom); b = WIDTH'($urandom);
         if (done) begin
            edges = i;
            if (busy) busy_ok = 1'b0;
            break;
         end
         if (!busy) busy_ok = 1'b0;
         if ({gt, lt, eq} !== prev) held_ok = 1'b0;
      end
   endtask

   task automatic test_reset;
      @(posedge clk); #1;
      n_cmp++;
      if ({busy, done, gt, lt, eq} !== 5'b0) begin
         n_err++; $display("FAIL reset_active: got %b want 00000", {busy, done, gt, lt, eq});
      end
      @(negedge clk); rst = 1'b0;
      repeat (2) @(posedge clk); #1;
      n_cmp++;
      if ({busy, done, gt, lt, eq} !== 5'b0) begin
         n_err++; $display("FAIL reset_release: got %b want 00000", {busy, done, gt, lt, eq});
      end
   endtask

   task automatic test_directed;
      logic [WIDTH-1:0] va [4] = '{8'h80, 8'hA5, 8'h12, 8'h01};
      logic [WIDTH-1:0] vb [4] = '{8'h7F, 8'hA5, 8'h13, 8'h00};
      int lat [4] = '{EARLY ? 1 : 4, 4, 4, EARLY ? 4 : 4};
      logic [2:0] res [4] = '{3'b100, 3'b001, 3'b010, 3'b100};
      int e; bit bok, hok;
      for (int t = 0; t < 4; t++) begin
         launch(va[t], vb[t]);
         n_cmp++;
         if (busy !== 1'b1) begin
            n_err++; $display("FAIL dir%0d_busy_accept: got %b want 1", t, busy);
         end
         wait_done(e, bok, hok);
         n_cmp++;
         if (e !== lat[t]) begin
            n_err++; $display("FAIL dir%0d_latency: got %0d want %0d", t, e, lat[t]);
         end
         n_cmp++;
         if ({gt, lt, eq} !== res[t]) begin
            n_err++; $display("FAIL dir%0d_result: got %b want %b", t, {gt, lt, eq}, res[t]);
         end
         n_cmp++;
         if (!bok || !hok) begin
            n_err++; $display("FAIL dir%0d_busy_hold: got busy_ok=%0b held_ok=%0b want 1 1", t, bok, hok);
         end
         @(posedge clk); #1;
         n_cmp++;
         if (done !== 1'b0 || {gt, lt, eq} !== res[t]) begin
            n_err++; $display("FAIL dir%0d_done_pulse: got done=%b res=%b want 0 %b", t, done, {gt, lt, eq}, res[t]);
         end
      end
   endtask

   task automatic test_busy_ignore;
      int e, extra; bit bok, hok;
      launch(8'h12, 8'h13);
      @(negedge clk);
      a = 8'hFF; b = 8'h00; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(e, bok, hok);
      n_cmp++;
      if (e + 1 !== 4 || {gt, lt, eq} !== 3'b010) begin
         n_err++; $display("FAIL busy_ignore: got lat=%0d res=%b want 4 010", e + 1, {gt, lt, eq});
      end
      extra = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done) extra++;
      end
      n_cmp++;
      if (extra !== 0) begin
         n_err++; $display("FAIL busy_ignore_second_done: got %0d want 0", extra);
      end
   endtask

   task automatic test_back_to_back;
      int e; bit bok, hok;
      launch(8'hC0, 8'h40);
      wait_done(e, bok, hok);
      a = 8'h3C; b = 8'h3D; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0 || {gt, lt, eq} !== 3'b100) begin
         n_err++; $display("FAIL b2b_accept: got busy=%b done=%b res=%b want 1 0 100", busy, done, {gt, lt, eq});
      end
      wait_done(e, bok, hok);
      n_cmp++;
      if (e !== exp_lat(8'h3C, 8'h3D) || {gt, lt, eq} !== 3'b010 || !hok) begin
         n_err++; $display("FAIL b2b_second: got lat=%0d res=%b held=%0b want %0d 010 1",
                           e, {gt, lt, eq}, hok, exp_lat(8'h3C, 8'h3D));
      end
   endtask

   task automatic test_reset_mid;
      int dones;
      launch(8'h01, 8'h02);
      @(posedge clk); #1;
      @(negedge clk); rst = 1'b1;
      #1;
      n_cmp++;
      if ({busy, done, gt, lt, eq} !== 5'b0) begin
         n_err++; $display("FAIL reset_mid_async: got %b want 00000", {busy, done, gt, lt, eq});
      end
      @(negedge clk); rst = 1'b0;
      dones = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done || busy || gt || lt || eq) dones++;
      end
      n_cmp++;
      if (dones !== 0) begin
         n_err++; $display("FAIL reset_mid_quiet: got %0d active cycles want 0", dones);
      end
   endtask

   task automatic test_random;
      logic [WIDTH-1:0] x, y;
      int e; bit bok, hok;
      for (int t = 0; t < 40; t++) begin
         x = WIDTH'($urandom);
         case ($urandom_range(0, 3))
            0: y = x;
            1: y = x ^ WIDTH'($urandom_range(1, 3));
            2: y = x ^ WIDTH'($urandom_range(1, 15));
            default: y = WIDTH'($urandom);
         endcase
         launch(x, y);
         wait_done(e, bok, hok);
         n_cmp++;
         if (e !== exp_lat(x, y) || {gt, lt, eq} !== exp_res(x, y) || !bok || !hok) begin
            n_err++;
            $display("FAIL rand%0d a=%h b=%h: got lat=%0d res=%b busy_ok=%0b held_ok=%0b want %0d %b 1 1",
                     t, x, y, e, {gt, lt, eq}, bok, hok, exp_lat(x, y), exp_res(x, y));
         end
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_busy_ignore;
      test_back_to_back;
      test_reset_mid;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
